slave_frame_tx: RTL

Host-bound frame transmitter for the USB-CDC slave path: the outbound counterpart of the configuration frame parser. It accepts (module, cmd, data) response requests from slave-side logic, such as config acks, readbacks and error reports. Each request is serialized as the 6-byte frame A5 / module / cmd / data / checksum / 5A onto a byte stream toward the CDC TX FIFO, with full valid/ready backpressure.

---
 rtl/slave_frame_pkg.sv | 48 ++++
 rtl/slave_frame_req_fifo.sv | 60 ++++++
 rtl/slave_frame_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/slave_frame_pkg.sv
// Shared constants, state encoding and request payload for the slave-side
// host frame path (A5 / module / cmd / data / chk / 5A). The config frame
// parser imports the same constants.
package slave_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned REQ_W  = 3 * BYTE_W;

    // Frame delimiters
    localparam logic [BYTE_W-1:0] START_BYTE = 8'hA5;
    localparam logic [BYTE_W-1:0] END_BYTE   = 8'h5A;

    // Module identifiers
    localparam logic [BYTE_W-1:0] MODULE_SPI = 8'h01;
    localparam logic [BYTE_W-1:0] MODULE_I2C = 8'h02;

    // Command codes, shared numbering for the SPI and I2C modules
    localparam logic [BYTE_W-1:0] CMD_01 = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_02 = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_03 = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_04 = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_05 = 8'h05;
    localparam logic [BYTE_W-1:0] CMD_06 = 8'h06;

    // Transmit FSM; each S_x state drives the matching frame byte
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_START = 3'd1,
        S_MOD   = 3'd2,
        S_CMD   = 3'd3,
        S_DATA  = 3'd4,
        S_CHK   = 3'd5,
        S_END   = 3'd6
    } tx_state_e;

    // One response request; field order matches wire byte order
    typedef struct packed {
        logic [BYTE_W-1:0] mod;
        logic [BYTE_W-1:0] cmd;
        logic [BYTE_W-1:0] data;
    } frame_req_t;

    // Frame checksum: XOR of the three payload bytes
    function automatic logic [BYTE_W-1:0] frame_chk(input frame_req_t req);
        return req.mod ^ req.cmd ^ req.data;
    endfunction

endpackage

// File: rtl/slave_frame_req_fifo.sv
// Synchronous request FIFO. Full/empty come from read/write pointers that
// carry one extra wrap bit. pop_data shows the head entry whenever non-empty.
// Ports:
//   clk, rst_n          clock, async active-low reset (empties the FIFO)
//   push, push_data     write request (ignored when full)
//   pop, pop_data       read request (ignored when empty), head entry
//   full, empty         occupancy flags
module slave_frame_req_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index, different wrap bit means the writer lapped the reader
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/slave_frame_tx.sv
// Host-bound frame transmitter. Serializes (module, cmd, data) response
// requests as A5 / module / cmd / data / chk / 5A toward the CDC TX FIFO
// with valid/ready flow control on both sides.
// Build option: define SLAVE_FRAME_TX_FIFO_EN to queue requests in a
// FIFO_DEPTH-entry FIFO (gap-free back-to-back frames); otherwise a single
// frame register set is loaded straight from req_* while idle.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid, req_ready             request handshake
//   req_module, req_cmd, req_data    request payload
//   tx_data, tx_valid, tx_ready      outbound byte stream
//   busy                             FSM not in IDLE
//   frame_done                       one-cycle pulse after the END byte transfers
module slave_frame_tx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_module,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    import slave_frame_pkg::*;

    tx_state_e         state_q;
    tx_state_e         state_d;
    frame_req_t        frame_q;
    logic [BYTE_W-1:0] chk_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [BYTE_W-1:0] tx_data_d;
    logic              active_q;
    logic              frame_done_q;
    logic              frame_done_d;
    logic              take_c;
    logic              tx_hs_c;
    logic              src_avail_c;
    frame_req_t        src_req_c;
    frame_req_t        req_in_c;

    assign req_in_c = {req_module, req_cmd, req_data};
    assign tx_hs_c  = active_q & tx_ready;

`ifdef SLAVE_FRAME_TX_FIFO_EN
    // Requests queue here; the FSM pops the head when it starts a frame
    logic       fifo_full;
    logic       fifo_empty;
    frame_req_t fifo_head;

    slave_frame_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data (req_in_c),
        .pop       (take_c),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign req_ready   = ~fifo_full;
    assign src_avail_c = ~fifo_empty;
    assign src_req_c   = fifo_head;
`else
    // Direct load: ready only while idle, so the frame registers are never
    // overwritten mid-frame
    logic req_ready_q;
    logic unused_fifo_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q <= 1'b1;
        end else begin
            req_ready_q <= (state_d == IDLE);
        end
    end

    assign req_ready         = req_ready_q;
    assign src_avail_c       = req_valid & req_ready_q;
    assign src_req_c         = req_in_c;
    // Depth only matters when the request FIFO is built
    assign unused_fifo_depth = ^FIFO_DEPTH;
`endif

    // Next state, frame load strobe and next output byte
    always_comb begin
        state_d      = state_q;
        take_c       = 1'b0;
        frame_done_d = 1'b0;
        tx_data_d    = '0;

        case (state_q)
            IDLE: begin
                if (src_avail_c) begin
                    take_c  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (tx_hs_c) state_d = S_MOD;
            S_MOD:   if (tx_hs_c) state_d = S_CMD;
            S_CMD:   if (tx_hs_c) state_d = S_DATA;
            S_DATA:  if (tx_hs_c) state_d = S_CHK;
            S_CHK:   if (tx_hs_c) state_d = S_END;
            S_END: begin
                if (tx_hs_c) begin
                    frame_done_d = 1'b1;
                    // Chain straight into the next frame when one is waiting
                    if (src_avail_c) begin
                        take_c  = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame registers are already valid for every state past S_START
        case (state_d)
            S_START: tx_data_d = START_BYTE;
            S_MOD:   tx_data_d = frame_q.mod;
            S_CMD:   tx_data_d = frame_q.cmd;
            S_DATA:  tx_data_d = frame_q.data;
            S_CHK:   tx_data_d = chk_q;
            S_END:   tx_data_d = END_BYTE;
            default: tx_data_d = '0;
        endcase
    end

    // State, registered outputs and frame capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_q      <= '0;
            chk_q        <= '0;
        end else begin
            state_q      <= state_d;
            active_q     <= (state_d != IDLE);
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            if (take_c) begin
                frame_q <= src_req_c;
                chk_q   <= frame_chk(src_req_c);
            end
        end
    end

    // tx_valid and busy both mean "not IDLE"
    assign tx_valid   = active_q;
    assign busy       = active_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;

endmodule
